// File: rtl/param_instruction_memory.sv
// Instruction memory with a LOAD/RUN controller. In LOAD the program is
// written through the load port. In RUN, fetches return the registered word
// one cycle later, and the fetch pipeline supports stall and flush.
module param_instruction_memory #(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 1024,
  parameter int              ADDR_W    = 32,
  parameter bit              BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hE1A00000,
  parameter bit              BOOT_RUN  = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              ready,
  output logic [DATA_W-1:0] instruction,
  output logic              valid,
  output logic              fault,
  output logic              load_err
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] DEPTH64 = 64'(DEPTH);

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] fetch_word, load_word;
  logic              fetch_legal, load_legal;
  logic [IDX_W-1:0]  fetch_idx, load_idx;

  // Address decode: the full word index is range-checked before it is
  // narrowed. Out-of-range addresses therefore never alias onto low words.
  always_comb begin
    fetch_word  = BYTE_ADDR ? (fetch_addr >> 2) : fetch_addr;
    load_word   = BYTE_ADDR ? (load_addr >> 2) : load_addr;
    fetch_legal = (64'(fetch_word) < DEPTH64) &&
                  (!BYTE_ADDR || (fetch_addr[1:0] == 2'b00));
    load_legal  = (64'(load_word) < DEPTH64) &&
                  (!BYTE_ADDR || (load_addr[1:0] == 2'b00));
    fetch_idx   = fetch_word[IDX_W-1:0];
    load_idx    = load_word[IDX_W-1:0];
  end

  // State register. Reset picks the boot state.
  always_ff @(posedge clock) begin
    if (reset) state <= BOOT_RUN ? RUN : LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic. Program load ends on load_done. RUN is left only by reset.
  always_comb begin
    state_nxt = state;
    ready     = (state == RUN);
    unique case (state)
      LOAD:    if (load_done) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  // Program-load write port. Reset blocks the write, but it does not clear the array.
  always_ff @(posedge clock) begin
    if (!reset && (state == LOAD) && load_we && load_legal)
      mem[load_idx] <= load_data;
  end

  // Fetch output stage. Priority is: reset, then LOAD, then flush, then stall, then fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= NOP_WORD;
      valid       <= 1'b0;
      fault       <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= (state == LOAD) && load_we && !load_legal;
      if (state == LOAD || flush) begin
        instruction <= NOP_WORD;
        valid       <= 1'b0;
        fault       <= 1'b0;
      end else if (stall) begin
        instruction <= instruction;
        valid       <= valid;
        fault       <= fault;
      end else if (fetch_req) begin
        instruction <= fetch_legal ? mem[fetch_idx] : NOP_WORD;
        valid       <= 1'b1;
        fault       <= !fetch_legal;
      end else begin
        instruction <= NOP_WORD;
        valid       <= 1'b0;
        fault       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_instruction_memory.sv
// Scoreboard bench for param_instruction_memory using the default parameters.
// The driver queues the expected outputs for every clock edge it drives.
// A separate monitor pops each entry after the edge and compares it.
module tb_param_instruction_memory;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clock, reset, fetch_req, stall, flush, load_we, load_done;
  logic [31:0] fetch_addr, load_addr, load_data;
  logic        ready, valid, fault, load_err;
  logic [31:0] instruction;

  typedef struct packed {
    logic [31:0] instr;
    logic        vld;
    logic        flt;
    logic        rdy;
    logic        lerr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  param_instruction_memory dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .flush(flush), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done), .ready(ready),
    .instruction(instruction), .valid(valid), .fault(fault), .load_err(load_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a new output after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instruction", instruction, e.instr);
        chk("valid", 32'(valid), 32'(e.vld));
        chk("fault", 32'(fault), 32'(e.flt));
        chk("ready", 32'(ready), 32'(e.rdy));
        chk("load_err", 32'(load_err), 32'(e.lerr));
      end
    end
  end

  task automatic idle();
    reset = 0; fetch_req = 0; fetch_addr = '0; stall = 0; flush = 0;
    load_we = 0; load_addr = '0; load_data = '0; load_done = 0;
  endtask

  // Queue the expected response for the next edge, then advance to the following negedge.
  task automatic step(input logic [31:0] i, input logic v, input logic f,
                      input logic r, input logic le);
    exp_t e;
    e.instr = i; e.vld = v; e.flt = f; e.rdy = r; e.lerr = le;
    exp_q.push_back(e);
    @(negedge clock);
    idle();
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req = 1; fetch_addr = a;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1; load_addr = a; load_data = d;
  endtask

  initial begin
    idle();
    reset = 1;
    step(NOP, 0, 0, 0, 0);
    reset = 1; load(32'h0, 32'h11111111);
    step(NOP, 0, 0, 0, 0);
    // Program load. Fetch requests made in LOAD are ignored.
    load(32'h0, 32'hE3A00014); fetch(32'h0);
    step(NOP, 0, 0, 0, 0);
    load(32'h4, 32'hE3A01A01);
    step(NOP, 0, 0, 0, 0);
    load(32'h2000, 32'hDEADBEEF);
    step(NOP, 0, 0, 0, 1);
    step(NOP, 0, 0, 0, 0);
    load(32'h6, 32'hDEADBEEF);
    step(NOP, 0, 0, 0, 1);
    load(32'h1000, 32'hBADBAD00);
    step(NOP, 0, 0, 0, 1);
    load(32'h8, 32'h12345678); load_done = 1;
    step(NOP, 0, 0, 1, 0);
    // Normal fetches with one-cycle latency.
    fetch(32'h0);    step(32'hE3A00014, 1, 0, 1, 0);
    fetch(32'h4);    step(32'hE3A01A01, 1, 0, 1, 0);
    fetch(32'h8);    step(32'h12345678, 1, 0, 1, 0);
    // Out-of-range and misaligned fetches produce a faulting NOP.
    fetch(32'h1000); step(NOP, 1, 1, 1, 0);
    fetch(32'h6);    step(NOP, 1, 1, 1, 0);
    step(NOP, 0, 0, 1, 0);
    // Stall holds the output for three cycles.
    fetch(32'h0);    step(32'hE3A00014, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      fetch(32'h4); stall = 1; step(32'hE3A00014, 1, 0, 1, 0);
    end
    fetch(32'h4);    step(32'hE3A01A01, 1, 0, 1, 0);
    fetch(32'h1000); step(NOP, 1, 1, 1, 0);
    stall = 1;       step(NOP, 1, 1, 1, 0);
    // Flush overrides both stall and fetch_req.
    fetch(32'h0);    step(32'hE3A00014, 1, 0, 1, 0);
    fetch(32'h4); stall = 1; flush = 1; step(NOP, 0, 0, 1, 0);
    // In RUN the load port is ignored.
    fetch(32'h0); load(32'h0, 32'hDEADBEEF); load_done = 1;
    step(32'hE3A00014, 1, 0, 1, 0);
    load(32'h2000, 32'h0);
    step(NOP, 0, 0, 1, 0);
    fetch(32'h0);    step(32'hE3A00014, 1, 0, 1, 0);
    // Reset during RUN returns to LOAD and drops the in-flight fetch.
    reset = 1; fetch(32'h4);
    step(NOP, 0, 0, 0, 0);
    reset = 1; load(32'h0, 32'hBAD0BAD0);
    step(NOP, 0, 0, 0, 0);
    load_done = 1;
    step(NOP, 0, 0, 1, 0);
    fetch(32'h0);    step(32'hE3A00014, 1, 0, 1, 0);
    fetch(32'h8);    step(32'h12345678, 1, 0, 1, 0);
    // Drain the scoreboard, with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
